// File: rtl/ptx_call_sched_if.sv
// Bundle of the call-scheduler signals shared between the transactor
// request logic / PTX channel (master) and the scheduler itself (slave).
interface ptx_call_sched_if #(
  parameter int N_REQ = 4,
  parameter int TW    = 8
);
  logic                       callEvOn;
  logic [1:0]                 dly;
  logic [N_REQ-1:0]           req;
  logic [N_REQ*TW-1:0]        reqTag;
  logic [N_REQ-1:0]           gnt;
  logic                       callEv;
  logic [TW-1:0]              callTag;
  logic [$clog2(N_REQ)-1:0]   callSrc;
  logic                       xptRtn;
  logic [N_REQ-1:0]           done;
  logic                       tmoErr;
  logic                       hasPTX;

  modport master (
    output callEvOn, dly, req, reqTag, xptRtn,
    input  gnt, callEv, callTag, callSrc, done, tmoErr, hasPTX
  );

  modport slave (
    input  callEvOn, dly, req, reqTag, xptRtn,
    output gnt, callEv, callTag, callSrc, done, tmoErr, hasPTX
  );
endinterface

// File: rtl/ptx_call_sched.sv
// Round-robin scheduler putting one call at a time from N_REQ requesters
// onto the single PTX call channel, waiting for the export return (with a
// timeout) and then holding off for a programmable gap before the next call.
module ptx_call_sched #(
  parameter int N_REQ   = 4,
  parameter int TW      = 8,
  parameter int TMO_CYC = 1024
) (
  input logic             uClk,
  input logic             uRst,
  ptx_call_sched_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TMO_CYC);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     idx_q;
  logic [TW-1:0]     callTag_q;
  logic [1:0]        dly_q;
  logic [1:0]        gapCnt_q;
  logic [CW-1:0]     waitCnt_q;
  logic [CW-1:0]     waitCnt_d;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic              callEv_q;
  logic              tmoErr_q;
  logic              hasPTX_q;

  logic              pickValid;
  logic [IW-1:0]     pickIdx;
  logic [TW-1:0]     pickTag;
  logic              tmoHit;

  // Round-robin pick: scan downward so the requester closest to ptr wins.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(ptr_q) + i) % N_REQ]) begin
        pickValid = 1'b1;
        pickIdx   = IW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  assign pickTag   = bus.reqTag[int'(pickIdx)*TW +: TW];
  assign waitCnt_d = waitCnt_q + CW'(1);
  assign tmoHit    = (waitCnt_d == CW'(TMO_CYC - 1));

  // Call sequencing FSM; every output is a register updated here.
  always_ff @(posedge uClk) begin
    if (uRst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      callTag_q <= '0;
      dly_q     <= '0;
      gapCnt_q  <= '0;
      waitCnt_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      callEv_q  <= 1'b0;
      tmoErr_q  <= 1'b0;
      hasPTX_q  <= 1'b0;
    end else begin
      callEv_q <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      case (state_q)
        IDLE: begin
          if (bus.callEvOn && pickValid) begin
            idx_q     <= pickIdx;
            callTag_q <= pickTag;
            callEv_q  <= 1'b1;
            gnt_q     <= ONE_HOT0 << pickIdx;
            hasPTX_q  <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          dly_q     <= bus.dly;
          ptr_q     <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
          waitCnt_q <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          waitCnt_q <= waitCnt_d;
          if (bus.xptRtn || tmoHit) begin
            if (!bus.xptRtn) begin
              tmoErr_q <= 1'b1;
            end
            done_q <= ONE_HOT0 << idx_q;
            if (dly_q != 2'd0) begin
              gapCnt_q <= dly_q - 2'd1;
              state_q  <= GAP;
            end else begin
              hasPTX_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        GAP: begin
          if (gapCnt_q == 2'd0) begin
            hasPTX_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            gapCnt_q <= gapCnt_q - 2'd1;
          end
        end
        default: begin
          hasPTX_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.callEv  = callEv_q;
  assign bus.callTag = callTag_q;
  assign bus.callSrc = idx_q;
  assign bus.done    = done_q;
  assign bus.tmoErr  = tmoErr_q;
  assign bus.hasPTX  = hasPTX_q;

endmodule
